// File: rtl/piso_pkg.sv
// Shared types and constants for the parallel-in, serial-out transmitter.
package piso_pkg;

  localparam int unsigned PISO_DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } piso_state_e;

endpackage

// File: rtl/piso_bit_counter.sv
// Bit counter for the serializer: clears on load, counts transfers, flags the last data bit.
module piso_bit_counter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic inc,
  output logic tc_c
);

  localparam int unsigned CW = $clog2(WIDTH);

  logic [CW-1:0] cnt;

  // Holds at WIDTH-1 once reached so the count never wraps before the next clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (inc && !tc_c) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tc_c = (cnt == CW'(WIDTH - 1));

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in, serial-out transmitter: MSB-first with valid/ready on both sides.
// Define PISO_PARITY_EN to append an even-parity bit after each word.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int unsigned WIDTH = PISO_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             serial_out,
  output logic             serial_valid,
  input  logic             serial_ready,
  output logic             done
);

  piso_state_e      state;
  logic [WIDTH-1:0] shreg;
  logic             cnt_clear;
  logic             cnt_inc;
  logic             last_bit_c;
`ifdef PISO_PARITY_EN
  logic             par;
`endif

  assign cnt_clear = (state == IDLE) && load_valid;
  assign cnt_inc   = (state == SHIFT) && serial_valid && serial_ready;

  piso_bit_counter #(.WIDTH(WIDTH)) u_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (cnt_clear),
    .inc     (cnt_inc),
    .tc_c    (last_bit_c)
  );

  // FSM, shift register and output registers; serial_out is preloaded with the next bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      shreg        <= '0;
      serial_out   <= 1'b0;
      serial_valid <= 1'b0;
      load_ready   <= 1'b1;
      done         <= 1'b0;
`ifdef PISO_PARITY_EN
      par          <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (load_valid) begin
            state        <= SHIFT;
            shreg        <= d;
            serial_out   <= d[WIDTH-1];
            serial_valid <= 1'b1;
            load_ready   <= 1'b0;
`ifdef PISO_PARITY_EN
            par          <= ^d;
`endif
          end
        end
        SHIFT: begin
          if (serial_ready) begin
            shreg <= {shreg[WIDTH-2:0], 1'b0};
            if (last_bit_c) begin
`ifdef PISO_PARITY_EN
              state        <= PARITY;
              serial_out   <= par;
`else
              state        <= IDLE;
              serial_out   <= 1'b0;
              serial_valid <= 1'b0;
              load_ready   <= 1'b1;
              done         <= 1'b1;
`endif
            end else begin
              serial_out <= shreg[WIDTH-2];
            end
          end
        end
`ifdef PISO_PARITY_EN
        PARITY: begin
          if (serial_ready) begin
            state        <= IDLE;
            serial_out   <= 1'b0;
            serial_valid <= 1'b0;
            load_ready   <= 1'b1;
            done         <= 1'b1;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Scoreboard bench for piso_serializer: stimulus queues expected bits, a monitor checks them.
module tb_piso_serializer;

  localparam int unsigned W = 4;
`ifdef PISO_PARITY_EN
  localparam int FRAME = W + 1;
`else
  localparam int FRAME = W;
`endif

  typedef struct packed {
    logic b;
    logic last;
  } exp_t;

  logic         clk;
  logic         reset_n;
  logic [W-1:0] d;
  logic         load_valid;
  logic         load_ready;
  logic         serial_out;
  logic         serial_valid;
  logic         serial_ready;
  logic         done;

  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  piso_serializer #(.WIDTH(W)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .d            (d),
    .load_valid   (load_valid),
    .load_ready   (load_ready),
    .serial_out   (serial_out),
    .serial_valid (serial_valid),
    .serial_ready (serial_ready),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic push_word(input logic [W-1:0] w);
    exp_t e;
    for (int i = W - 1; i >= 0; i--) begin
      e.b    = w[i];
      e.last = (i == 0) && (FRAME == W);
      exp_q.push_back(e);
    end
`ifdef PISO_PARITY_EN
    e.b    = ^w;
    e.last = 1'b1;
    exp_q.push_back(e);
`endif
  endtask

  // Called at posedge+1; returns at posedge+1 of the cycle showing the first bit.
  task automatic send(input logic [W-1:0] w);
    int n;
    n = 0;
    d = w;
    load_valid = 1'b1;
    while (!load_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("load_accept", 32'(load_ready), 32'd1);
    if (load_ready) push_word(w);
    @(posedge clk); #1;
    load_valid = 1'b0;
    d = ~w;
    check("first_valid", 32'(serial_valid), 32'd1);
    check("first_bit", 32'(serial_out), 32'(w[W-1]));
    check("busy_not_ready", 32'(load_ready), 32'd0);
  endtask

  task automatic wait_done(input int expn);
    int n;
    n = 0;
    while (!done && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("done_latency", 32'(n), 32'(expn));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Monitor: compares each transferred bit and the Done/idle cycle that follows a frame.
  initial begin : monitor
    logic expect_done;
    exp_t e;
    expect_done = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        expect_done = 1'b0;
        check("reset_outputs", 32'({load_ready, serial_valid, serial_out, done}), 32'b1000);
      end else begin
        check("done", 32'(done), 32'(expect_done));
        if (expect_done) check("idle_after_frame", 32'({load_ready, serial_valid}), 32'b10);
        expect_done = 1'b0;
        if (serial_valid) begin
          if (exp_q.size() == 0) begin
            check("spurious_valid", 32'(serial_valid), 32'd0);
          end else if (serial_ready) begin
            e = exp_q.pop_front();
            check("serial_bit", 32'(serial_out), 32'(e.b));
            expect_done = e.last;
          end else begin
            e = exp_q[0];
            check("serial_hold", 32'(serial_out), 32'(e.b));
          end
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    logic [W-1:0] dv[12];
    int last_acc;
    dv = '{4'h9, 4'h3, 4'hc, 4'h5, 4'ha, 4'h7, 4'he, 4'h1, 4'hd, 4'h2, 4'hf, 4'h4};
    reset_n      = 1'b0;
    d            = '0;
    load_valid   = 1'b0;
    serial_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Basic frame with continuous downstream ready.
    send(4'b1011);
    wait_done(FRAME);
    drain();

    // Downstream stalls for three cycles after the first transfer.
    send(4'b0110);
    @(posedge clk); #1;
    serial_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("stall_valid", 32'(serial_valid), 32'd1);
      check("stall_bit", 32'(serial_out), 32'd1);
      @(posedge clk); #1;
    end
    serial_ready = 1'b1;
    wait_done(FRAME - 1);
    drain();

    // Reset in the middle of a frame discards it.
    send(4'b1011);
    repeat (2) begin
      @(posedge clk); #1;
    end
    reset_n = 1'b0;
    exp_q.delete();
    #1;
    check("async_reset", 32'({load_ready, serial_valid, serial_out, done}), 32'b1000);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    send(4'b1000);
    wait_done(FRAME);
    drain();

    // Load_Valid held high with D changing every cycle.
    last_acc = -1;
    for (int i = 0; i < 12; i++) begin
      d = dv[i];
      load_valid = 1'b1;
      if (load_ready) begin
        if (last_acc >= 0) check("issue_interval", 32'(i - last_acc), 32'(FRAME + 1));
        last_acc = i;
        push_word(dv[i]);
      end
      @(posedge clk); #1;
    end
    load_valid = 1'b0;
    drain();

    // All-zero word.
    send(4'b0000);
    wait_done(FRAME);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
